sr_piso_reader: RTL and testbench

//   Reads a daisy-chain of 74HC165 parallel-in/serial-out shift registers carrying the
//   box's button/switch panel. Complement of the 74HC595 display path: that path shifts

---
 rtl/sr_piso_reader_if.sv | 39 +++
 rtl/sr_piso_reader.sv | 211 +++++++++++++++++++++
 tb/tb_sr_piso_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sr_piso_reader_if.sv
// ============================================================================
// Module      : sr_piso_reader_if
// Description : Panel-input bundle between the 74HC165 chain reader and its
//               neighbours: chain pins, scan enable and parallel snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sr_piso_reader_if #(
  parameter int WIDTH = 16
);
  logic             EN;
  logic             SR_QH;
  logic             SR_PL_N;
  logic             SR_CLK;
  logic [WIDTH-1:0] data;
  logic             valid;

  // master = the reader itself; slave = chain + game logic side
  modport master (
    input  EN,
    input  SR_QH,
    output SR_PL_N,
    output SR_CLK,
    output data,
    output valid
  );

  modport slave (
    output EN,
    output SR_QH,
    input  SR_PL_N,
    input  SR_CLK,
    input  data,
    input  valid
  );
endinterface

`default_nettype wire

// File: rtl/sr_piso_reader.sv
// ============================================================================
// Module      : sr_piso_reader
// Description : Continuously scans a 74HC165 daisy-chain and publishes a
//               parallel snapshot with a 1-cycle valid strobe.
//               Optional debounce: define SR_PISO_READER_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_piso_reader #(
  parameter int WIDTH    = 16,
  parameter int DIV      = 25000,
  parameter int DB_COUNT = 3
) (
  input  wire logic          CLK1_50,
  input  wire logic          CLR,
  sr_piso_reader_if.master   bus
);

  localparam int c_CNT_W = $clog2(DIV);
  localparam int c_IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("sr_piso_reader: WIDTH must be >= 2");
    end
    if (DIV < 4) begin : g_bad_div
      $error("sr_piso_reader: DIV must be >= 4");
    end
    if (DB_COUNT < 1) begin : g_bad_db_count
      $error("sr_piso_reader: DB_COUNT must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_HIGH   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_tick;

  logic               r_qh_meta;
  logic               r_qh_sync;

  logic               r_pl_n;
  logic               r_sclk;
  logic [c_IDX_W-1:0] r_idx;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_data;
  logic               r_valid;

  logic               w_pl_n_nxt;
  logic               w_sclk_nxt;
  logic [c_IDX_W-1:0] w_idx_nxt;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic               w_done;
  logic               w_publish;

  assign w_tick = (r_cnt == c_CNT_MAX);

  // Free-running tick prescaler; every FSM step is paced by it
  always_ff @(posedge CLK1_50) begin
    if (CLR) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK1_50) begin
    if (CLR) begin
      r_qh_meta <= 1'b0;
      r_qh_sync <= 1'b0;
    end else begin
      r_qh_meta <= bus.SR_QH;
      r_qh_sync <= r_qh_meta;
    end
  end

  always_ff @(posedge CLK1_50) begin
    if (CLR) begin
      r_state <= ST_IDLE;
      r_pl_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pl_n  <= w_pl_n_nxt;
      r_sclk  <= w_sclk_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // Next-state and next-output decode; nothing moves except on a tick
  always_comb begin
    w_state_nxt = r_state;
    w_pl_n_nxt  = r_pl_n;
    w_sclk_nxt  = r_sclk;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_done      = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_pl_n_nxt = 1'b1;
          w_sclk_nxt = 1'b0;
          if (bus.EN) begin
            w_state_nxt = ST_LOAD;
            w_pl_n_nxt  = 1'b0;
          end
        end
        ST_LOAD: begin
          w_pl_n_nxt  = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          w_shreg_nxt = {r_shreg[WIDTH-2:0], r_qh_sync};
          w_sclk_nxt  = 1'b1;
          w_state_nxt = (r_idx == c_IDX_LAST) ? ST_DONE : ST_HIGH;
        end
        ST_HIGH: begin
          w_sclk_nxt  = 1'b0;
          w_idx_nxt   = r_idx + c_IDX_W'(1);
          w_state_nxt = ST_SAMPLE;
        end
        ST_DONE: begin
          w_sclk_nxt  = 1'b0;
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_pl_n_nxt  = 1'b1;
          w_sclk_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

`ifdef SR_PISO_READER_DEBOUNCE_EN
  localparam int c_DB_W = $clog2(DB_COUNT + 1);
  localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DB_COUNT);

  logic [WIDTH-1:0]  r_last;
  logic [c_DB_W-1:0] r_db_cnt;
  logic [c_DB_W-1:0] w_db_cnt_nxt;

  // Match counter saturates so a long-stable panel keeps qualifying
  always_comb begin
    w_db_cnt_nxt = r_db_cnt;
    if (w_done) begin
      if (r_shreg == r_last) begin
        w_db_cnt_nxt = (r_db_cnt == c_DB_MAX) ? c_DB_MAX : r_db_cnt + c_DB_W'(1);
      end else begin
        w_db_cnt_nxt = c_DB_W'(1);
      end
    end
  end

  assign w_publish = w_done && (w_db_cnt_nxt == c_DB_MAX) && (r_shreg != r_data);

  always_ff @(posedge CLK1_50) begin
    if (CLR) begin
      r_last   <= '0;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= w_db_cnt_nxt;
      if (w_done) begin
        r_last <= r_shreg;
      end
    end
  end
`else
  assign w_publish = w_done;
`endif

  always_ff @(posedge CLK1_50) begin
    if (CLR) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_publish;
      if (w_publish) begin
        r_data <= r_shreg;
      end
    end
  end

  assign bus.SR_PL_N = r_pl_n;
  assign bus.SR_CLK  = r_sclk;
  assign bus.data    = r_data;
  assign bus.valid   = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_sr_piso_reader.sv
// ============================================================================
// Module      : tb_sr_piso_reader
// Description : Self-checking bench: 16-bit 74HC165 chain model, vector table,
//               randomized scans against a per-scan reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_piso_reader;

  localparam int c_W   = 16;
  localparam int c_DIV = 4;
  localparam int c_DB  = 3;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sr_piso_reader_if #(.WIDTH(c_W)) bus ();

  sr_piso_reader #(.WIDTH(c_W), .DIV(c_DIV), .DB_COUNT(c_DB)) dut (
    .CLK1_50 (clk),
    .CLR     (clr),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // 74HC165 chain: async parallel load while PL_N low, shift on SR_CLK rise
  logic [c_W-1:0] chain_par = '0;
  logic [c_W-1:0] chain_sr  = '0;
  always @(posedge bus.SR_CLK or negedge bus.SR_PL_N) begin
    if (!bus.SR_PL_N) chain_sr <= chain_par;
    else              chain_sr <= {chain_sr[c_W-2:0], 1'b0};
  end
  assign bus.SR_QH = chain_sr[c_W-1];

  // Reference model: one call per completed scan with the word the chain held
  logic [c_W-1:0] m_hist[$];
  logic [c_W-1:0] m_data = '0;

  task automatic model_reset();
    m_hist.delete();
    m_data = '0;
  endtask

  task automatic model_step(input logic [c_W-1:0] w, output logic exp_v,
                            output logic [c_W-1:0] exp_d);
`ifdef SR_PISO_READER_DEBOUNCE_EN
    bit same;
    m_hist.push_back(w);
    if (m_hist.size() > c_DB) void'(m_hist.pop_front());
    same = (m_hist.size() == c_DB);
    foreach (m_hist[k]) if (m_hist[k] != w) same = 1'b0;
    exp_v = same && (w != m_data);
`else
    exp_v = 1'b1;
`endif
    if (exp_v) m_data = w;
    exp_d = m_data;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one scan: wait for PL_N to fall, then watch 134 cycles
  time last_valid_t = 0;
  task automatic scan(input logic [c_W-1:0] val, input int en_off_at, input int clr_at,
                      output int n_valid, output int t_valid, output int n_pl,
                      output int n_rise);
    bit   found = 1'b0;
    logic prev_clk;
    chain_par = val;
    n_valid = 0; t_valid = -1; n_pl = 0; n_rise = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (!bus.SR_PL_N) found = 1'b1;
    end
    if (!found) begin
      chk("pl_fall_timeout", 32'd0, 32'd1);
      return;
    end
    n_pl = 1;
    prev_clk = bus.SR_CLK;
    for (int i = 1; i <= 134; i++) begin
      @(negedge clk);
      if (!bus.SR_PL_N) n_pl++;
      if (bus.SR_CLK && !prev_clk) n_rise++;
      prev_clk = bus.SR_CLK;
      if (bus.valid) begin
        n_valid++;
        t_valid = i;
        last_valid_t = $time;
      end
      if (n_rise == en_off_at) bus.EN = 1'b0;
      if (clr_at >= 0 && n_rise == clr_at) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_pl_n",  {31'd0, bus.SR_PL_N}, 32'd1);
        chk("clr_sclk",  {31'd0, bus.SR_CLK},  32'd0);
        chk("clr_valid", {31'd0, bus.valid},   32'd0);
        chk("clr_data",  {16'd0, bus.data},    32'd0);
        return;
      end
    end
  endtask

  typedef struct {
    logic [c_W-1:0] chain;
    logic           exp_v;
    logic [c_W-1:0] exp_d;
  } vec_t;

`ifdef SR_PISO_READER_DEBOUNCE_EN
  localparam int c_NT = 8;
`else
  localparam int c_NT = 6;
`endif
  vec_t tbl[c_NT];

  initial begin
    int nv, tv, npl, nr, viol_pl, viol_clk, viol_v;
    logic ev;
    logic [c_W-1:0] ed, val, prev;
    time t_prev;

`ifdef SR_PISO_READER_DEBOUNCE_EN
    tbl[0] = '{16'h0000, 1'b0, 16'h0000};
    tbl[1] = '{16'h0000, 1'b0, 16'h0000};
    tbl[2] = '{16'h0000, 1'b0, 16'h0000};
    tbl[3] = '{16'h0F0F, 1'b0, 16'h0000};
    tbl[4] = '{16'h0000, 1'b0, 16'h0000};
    tbl[5] = '{16'h0F0F, 1'b0, 16'h0000};
    tbl[6] = '{16'h0F0F, 1'b0, 16'h0000};
    tbl[7] = '{16'h0F0F, 1'b1, 16'h0F0F};
`else
    tbl[0] = '{16'hA5C3, 1'b1, 16'hA5C3};
    tbl[1] = '{16'hFFFF, 1'b1, 16'hFFFF};
    tbl[2] = '{16'h0001, 1'b1, 16'h0001};
    tbl[3] = '{16'h0000, 1'b1, 16'h0000};
    tbl[4] = '{16'h8000, 1'b1, 16'h8000};
    tbl[5] = '{16'h5555, 1'b1, 16'h5555};
`endif

    bus.EN = 1'b0;
    clr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_pl_n",  {31'd0, bus.SR_PL_N}, 32'd1);
      chk("rst_sclk",  {31'd0, bus.SR_CLK},  32'd0);
      chk("rst_data",  {16'd0, bus.data},    32'd0);
      chk("rst_valid", {31'd0, bus.valid},   32'd0);
    end
    clr = 1'b0;
    model_reset();
    bus.EN = 1'b1;

    t_prev = 0;
    for (int k = 0; k < c_NT; k++) begin
      scan(tbl[k].chain, -1, -1, nv, tv, npl, nr);
      model_step(tbl[k].chain, ev, ed);
      chk($sformatf("tbl%0d_valid_cnt", k), nv, {31'd0, tbl[k].exp_v});
      chk($sformatf("tbl%0d_data", k), {16'd0, bus.data}, {16'd0, tbl[k].exp_d});
      if (k == 0) begin
        chk("pl_low_cycles", npl, 32'd4);
        chk("sclk_rises", nr, 32'd16);
        if (tbl[k].exp_v) chk("valid_latency", tv, 32'd132);
      end
`ifndef SR_PISO_READER_DEBOUNCE_EN
      if (k == 2) chk("valid_interval", (last_valid_t - t_prev) / 10, 32'd136);
`endif
      t_prev = last_valid_t;
    end

    prev = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      val = ($urandom_range(0, 1) == 1) ? prev : 16'($urandom);
      prev = val;
      scan(val, -1, -1, nv, tv, npl, nr);
      model_step(val, ev, ed);
      chk($sformatf("rnd%0d_valid_cnt", k), nv, {31'd0, ev});
      chk($sformatf("rnd%0d_data", k), {16'd0, bus.data}, {16'd0, ed});
    end

    // EN dropped mid-scan: scan finishes, then the chain interface goes quiet
    scan(16'h3C5A, 7, -1, nv, tv, npl, nr);
    model_step(16'h3C5A, ev, ed);
    chk("enoff_valid_cnt", nv, {31'd0, ev});
    chk("enoff_data", {16'd0, bus.data}, {16'd0, ed});
    chk("enoff_rises", nr, 32'd16);
    viol_pl = 0; viol_clk = 0; viol_v = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!bus.SR_PL_N) viol_pl++;
      if (bus.SR_CLK)   viol_clk++;
      if (bus.valid)    viol_v++;
    end
    chk("idle_pl_n", viol_pl, 32'd0);
    chk("idle_sclk", viol_clk, 32'd0);
    chk("idle_valid", viol_v, 32'd0);

    // Reset pulse mid-scan, then a clean scan
    bus.EN = 1'b1;
    scan(16'hBEEF, -1, 7, nv, tv, npl, nr);
    chk("abort_no_valid", nv, 32'd0);
    model_reset();
    scan(16'h1234, -1, -1, nv, tv, npl, nr);
    model_step(16'h1234, ev, ed);
    chk("post_clr_valid_cnt", nv, {31'd0, ev});
    chk("post_clr_data", {16'd0, bus.data}, {16'd0, ed});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
